// File: rtl/pwm_dac.sv
// PWM DAC: buffers 16-bit samples in a small FIFO, pops one per sample tick,
// and renders the top WIDTH bits as a glitch-free PWM duty cycle.
module pwm_dac #(
    parameter int WIDTH       = 8,
    parameter int CLOCK_FREQ  = 100_000_000,
    parameter int SAMPLE_FREQ = 2000,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic [15:0]                   sample_in,
    input  logic                          sample_valid,
    output logic                          sample_ready,
    output logic                          pwm_out,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int SAMPLE_DIV = CLOCK_FREQ / SAMPLE_FREQ;
    localparam int SCW        = $clog2(SAMPLE_DIV);
    localparam int PW         = $clog2(FIFO_DEPTH);
    localparam int LW         = PW + 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [SCW-1:0]   scnt_q, scnt_d;
    logic [WIDTH-1:0] pcnt_q, pcnt_d;
    logic [WIDTH-1:0] duty_pending_q, duty_pending_d;
    logic [WIDTH-1:0] duty_active_q, duty_active_d;
    logic             pwm_q, pwm_d;
    logic [LW-1:0]    level_q, level_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic             run;
    logic             tick;
    logic             empty;
    logic             push;
    logic             pop;
    logic             unused_lsbs;

    // Low sample bits are truncated away, never rounded.
    assign unused_lsbs = ^sample_in[15-WIDTH:0];

    assign fifo_level = level_q;
    assign pwm_out    = pwm_q;

    // Handshake, tick detection and next-state computation for all registers.
    always_comb begin
        run            = (state_q == RUN);
        tick           = run && (scnt_q == SCW'(SAMPLE_DIV - 1));
        empty          = (level_q == '0);
        sample_ready   = run && (level_q < LW'(FIFO_DEPTH));
        push           = sample_valid && sample_ready;
        pop            = tick && !empty;
        underrun       = tick && empty;

        state_d        = state_q;
        scnt_d         = scnt_q;
        pcnt_d         = pcnt_q;
        duty_pending_d = duty_pending_q;
        duty_active_d  = duty_active_q;
        pwm_d          = pwm_q;
        level_d        = level_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;

        case (state_q)
            IDLE: begin
                scnt_d         = '0;
                pcnt_d         = '0;
                duty_pending_d = '0;
                duty_active_d  = '0;
                pwm_d          = 1'b0;
                level_d        = '0;
                rd_ptr_d       = '0;
                wr_ptr_d       = '0;
                if (enable) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d        = IDLE;
                    scnt_d         = '0;
                    pcnt_d         = '0;
                    duty_pending_d = '0;
                    duty_active_d  = '0;
                    pwm_d          = 1'b0;
                    level_d        = '0;
                    rd_ptr_d       = '0;
                    wr_ptr_d       = '0;
                end else begin
                    scnt_d = tick ? '0 : scnt_q + 1'b1;
                    pcnt_d = pcnt_q + 1'b1;
                    pwm_d  = (pcnt_q < duty_active_q);
                    if (pcnt_q == '1) begin
                        duty_active_d = duty_pending_q;
                    end
                    if (pop) begin
                        duty_pending_d = mem_q[rd_ptr_q];
                        rd_ptr_d       = rd_ptr_q + 1'b1;
                    end
                    if (push) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                    if (push && !pop) begin
                        level_d = level_q + 1'b1;
                    end else if (pop && !push) begin
                        level_d = level_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            scnt_q         <= '0;
            pcnt_q         <= '0;
            duty_pending_q <= '0;
            duty_active_q  <= '0;
            pwm_q          <= 1'b0;
            level_q        <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
        end else begin
            state_q        <= state_d;
            scnt_q         <= scnt_d;
            pcnt_q         <= pcnt_d;
            duty_pending_q <= duty_pending_d;
            duty_active_q  <= duty_active_d;
            pwm_q          <= pwm_d;
            level_q        <= level_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
        end
    end

    // FIFO storage; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= sample_in[15 -: WIDTH];
        end
    end

endmodule

// File: tb/tb_pwm_dac.sv
// Bench for pwm_dac: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a behavioural model.
module tb_pwm_dac;

    localparam int W  = 4;
    localparam int CF = 1600;
    localparam int SF = 10;
    localparam int SD = CF / SF;
    localparam int D  = 4;
    localparam int PERIOD = 1 << W;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] sample_in = '0;
    logic        sample_valid = 1'b0;
    logic        sample_ready;
    logic        pwm_out;
    logic        underrun;
    logic [2:0]  fifo_level;

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    pwm_dac #(
        .WIDTH(W),
        .CLOCK_FREQ(CF),
        .SAMPLE_FREQ(SF),
        .FIFO_DEPTH(D)
    ) dut (
        .clk(clk),
        .reset(rst),
        .enable(enable),
        .sample_in(sample_in),
        .sample_valid(sample_valid),
        .sample_ready(sample_ready),
        .pwm_out(pwm_out),
        .underrun(underrun),
        .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit         m_run = 0;
    int         m_t = 0;        // cycles elapsed since RUN was entered
    logic [3:0] m_q[$];
    int         m_pend = 0;
    int         m_act = 0;
    bit         m_pwm = 0;

    function automatic void model_clear();
        m_run = 0; m_t = 0; m_q.delete(); m_pend = 0; m_act = 0; m_pwm = 0;
    endfunction

    always @(negedge clk) begin
        int  lvl;
        bit  tk, do_push, nxt_pwm;
        int  old_pend;
        if (rst) model_clear();
        lvl = m_q.size();
        tk  = m_run && (m_t % SD == SD - 1);
        chk("m_pwm",   pwm_out,      m_pwm);
        chk("m_level", fifo_level,   m_run ? lvl : 0);
        chk("m_ready", sample_ready, m_run && lvl < D);
        chk("m_under", underrun,     tk && lvl == 0);
        if (!rst) begin
            if (!m_run) begin
                if (enable) begin model_clear(); m_run = 1; end
            end else if (!enable) begin
                model_clear();
            end else begin
                do_push  = sample_valid && (lvl < D);
                nxt_pwm  = (m_t % PERIOD) < m_act;
                old_pend = m_pend;
                if (tk && lvl > 0) m_pend = m_q.pop_front();
                if (do_push) m_q.push_back(sample_in[15:12]);
                if (m_t % PERIOD == PERIOD - 1) m_act = old_pend;
                m_pwm = nxt_pwm;
                m_t++;
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic step();
        @(posedge clk); #1; cyc++;
    endtask

    task automatic start_run();
        rst = 1'b1; enable = 1'b0; sample_valid = 1'b0;
        step(); step();
        rst = 1'b0; enable = 1'b1;
        step();
        cyc = 0;
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic push1(input logic [15:0] v);
        sample_valid = 1'b1; sample_in = v;
        step();
        sample_valid = 1'b0;
    endtask

    task automatic count_high(input int n, output int h);
        h = 0;
        repeat (n) begin
            if (pwm_out) h++;
            step();
        end
    endtask

    initial begin
        int h;
        int p;
        #1 rst = 1'b1;
        step(); step();
        chk("reset_level", fifo_level, 0);
        chk("reset_ready", sample_ready, 0);
        chk("reset_pwm", pwm_out, 0);

        // Fill: 0x8000 then 0x4000
        start_run();
        chk("fill_ready0", sample_ready, 1);
        chk("fill_level0", fifo_level, 0);
        push1(16'h8000);
        chk("fill_level1", fifo_level, 1);
        push1(16'h4000);
        chk("fill_level2", fifo_level, 2);
        wait_to(SD - 1);
        chk("fill_pre_tick", fifo_level, 2);
        step();
        chk("fill_post_tick", fifo_level, 1);
        wait_to(200);
        count_high(16, h);
        chk("fill_duty8", h, 8);
        wait_to(2 * SD);
        chk("fill_tick2", fifo_level, 0);
        wait_to(360);
        count_high(16, h);
        chk("fill_duty4", h, 4);

        // Full
        start_run();
        sample_valid = 1'b1; sample_in = 16'hA5A5;
        repeat (4) step();
        chk("full_level4", fifo_level, 4);
        chk("full_ready0", sample_ready, 0);
        step();
        chk("full_5th_rejected", fifo_level, 4);
        wait_to(SD - 1);
        chk("full_ready_pre_tick", sample_ready, 0);
        step();
        chk("full_level3", fifo_level, 3);
        chk("full_ready1", sample_ready, 1);
        sample_valid = 1'b0;

        // Underrun, then push onto empty FIFO on a tick
        start_run();
        wait_to(SD - 2);
        chk("und_before", underrun, 0);
        step();
        chk("und_first", underrun, 1);
        step();
        chk("und_after", underrun, 0);
        chk("und_pwm_low", pwm_out, 0);
        wait_to(2 * SD - 1);
        chk("und_second", underrun, 1);
        sample_valid = 1'b1; sample_in = 16'h5000;
        step();
        sample_valid = 1'b0;
        chk("und_push_stored", fifo_level, 1);
        chk("und_cleared", underrun, 0);

        // Boundaries and push+tick at level 2
        start_run();
        push1(16'hFFFF);
        push1(16'h0FFF);
        wait_to(170);
        chk("bnd_no_early_change", pwm_out, 0);
        wait_to(177);
        chk("bnd_change_at_wrap", pwm_out, 1);
        wait_to(200);
        count_high(16, h);
        chk("bnd_duty15", h, 15);
        wait_to(300);
        push1(16'h2000);
        wait_to(2 * SD - 1);
        chk("bnd_level2_pre", fifo_level, 2);
        sample_valid = 1'b1; sample_in = 16'h3000;
        step();
        sample_valid = 1'b0;
        chk("bnd_push_pop_level", fifo_level, 2);
        wait_to(360);
        count_high(32, h);
        chk("bnd_duty0", h, 0);

        // Mid-operation reset
        start_run();
        push1(16'h1000); push1(16'h2000); push1(16'h3000);
        wait_to(40);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_pwm", pwm_out, 0);
        chk("mid_rst_ready", sample_ready, 0);
        step();
        rst = 1'b0;
        step();
        cyc = 0;
        wait_to(SD - 2);
        chk("mid_rst_no_tick", underrun, 0);
        step();
        chk("mid_rst_tick160", underrun, 1);

        // Mid-operation enable drop
        push1(16'h1000); push1(16'h2000); push1(16'h3000);
        enable = 1'b0;
        chk("mid_en_level_held", fifo_level, 3);
        step();
        chk("mid_en_level", fifo_level, 0);
        chk("mid_en_pwm", pwm_out, 0);
        enable = 1'b1;
        step();
        cyc = 0;
        wait_to(SD - 1);
        chk("mid_en_tick160", underrun, 1);

        // Randomized traffic, checked by the model
        p = 0;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) begin
                case ($urandom_range(2))
                    0: p = 2;
                    1: p = 20;
                    default: p = 70;
                endcase
            end
            sample_valid = ($urandom_range(99) < p);
            sample_in = 16'($urandom);
            if (rst) rst = ($urandom_range(1) == 0);
            else if ($urandom_range(799) == 0) rst = 1'b1;
            if (!enable) enable = ($urandom_range(3) == 0);
            else if ($urandom_range(499) == 0) enable = 1'b0;
            step();
        end
        rst = 1'b0; enable = 1'b0; sample_valid = 1'b0;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pwm_dac.md
PWM_DAC -- requirements
Module: pwm_dac

Interface
REQ-001 Parameter WIDTH, default 8: PWM resolution in bits; the PWM period is 2^WIDTH clk cycles.
REQ-002 Parameter CLOCK_FREQ, default 100_000_000: clk frequency in Hz.
REQ-003 Parameter SAMPLE_FREQ, default 2000: output sample update rate in Hz; SAMPLE_DIV = CLOCK_FREQ/SAMPLE_FREQ (integer, at least 2^WIDTH).
REQ-004 Parameter FIFO_DEPTH, default 4: sample buffer entries, a power of 2, at least 2.
REQ-005 clk  input  1  system clock; all logic is on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 enable  input  1  run enable; low means idle and flushed.
REQ-008 sample_in  input  16  unsigned sample in the same 16-bit format as the team's ADC output.
REQ-009 sample_valid  input  1  sample_in is valid this cycle.
REQ-010 sample_ready  output  1  block accepts a sample this cycle.
REQ-011 pwm_out  output  1  PWM output to the external RC filter.
REQ-012 underrun  output  1  one-cycle pulse when a sample tick finds the FIFO empty.
REQ-013 fifo_level  output  $clog2(FIFO_DEPTH)+1  current number of entries in the FIFO.

Function
REQ-014 The block SHALL have two states, IDLE and RUN: IDLE to RUN when enable=1; RUN to IDLE when enable=0, taking effect on the next edge.
REQ-015 In IDLE the block SHALL hold pwm_out=0, sample_ready=0, fifo_level=0, the FIFO flushed, the counters cleared and duty_active=0.
REQ-016 In RUN, sample_ready SHALL equal (fifo_level < FIFO_DEPTH), combinationally from the registered level.
REQ-017 A push SHALL occur on any edge where sample_valid and sample_ready are both 1 in RUN; sample_in[15:16-WIDTH] is the stored value.
REQ-018 sample_in[15-WIDTH:0] SHALL be discarded, with no rounding.
REQ-019 The sample counter SHALL count 0..SAMPLE_DIV-1 in RUN and wrap to 0.
REQ-020 The tick SHALL be the cycle where the sample counter equals SAMPLE_DIV-1.
REQ-021 On a tick with the FIFO non-empty, the head SHALL be popped into duty_pending.
REQ-022 On a tick with the FIFO empty, duty_pending SHALL be held and underrun SHALL pulse high for exactly that cycle.
REQ-023 If a push and a pop occur on the same edge, both SHALL take effect and fifo_level is unchanged.
REQ-024 A push onto an empty FIFO on a tick cycle SHALL NOT bypass the FIFO: the tick still reports underrun and the pushed sample is stored.
REQ-025 The PWM counter SHALL count 0..2^WIDTH-1 free-running in RUN and wrap.
REQ-026 When the PWM counter equals 2^WIDTH-1, duty_active SHALL load duty_pending, so duty changes only at a period boundary and no glitch occurs.
REQ-027 pwm_out SHALL be registered and SHALL be 1 exactly when pwm_counter < duty_active.
REQ-028 Duty 0 SHALL produce a constant low output; all-ones SHALL produce 2^WIDTH-1 high cycles per period.
REQ-029 Latency from a pop to the first pwm_out cycle reflecting the new value SHALL be at most 2^WIDTH+1 clk cycles.
REQ-030 The FIFO pointers SHALL wrap modulo FIFO_DEPTH.
REQ-031 Pushes SHALL be impossible when full because sample_ready=0; pops SHALL be impossible when empty.

Reset
REQ-032 While reset=1, asynchronously: state=IDLE, pwm_out=0, sample_ready=0, underrun=0, fifo_level=0, all counters 0, duty_pending=0, duty_active=0, FIFO pointers 0.
REQ-033 Reset asserted mid-operation SHALL discard all buffered samples; after release the block behaves as from power-up.
REQ-034 The first tick after release SHALL occur SAMPLE_DIV cycles after RUN is entered.

Verification
Common bench parameters: WIDTH=4, CLOCK_FREQ=1600, SAMPLE_FREQ=10, so SAMPLE_DIV=160; FIFO_DEPTH=4.
REQ-035 Fill test: enable=1, push 0x8000 then 0x4000. The first tick pops 0x8 and fifo_level goes 2 then 1; after the next period boundary pwm_out is high 8 of 16 cycles, and the second tick gives 4 of 16.
REQ-036 Full test: hold sample_valid=1 with no tick. After 4 pushes sample_ready=0 and fifo_level=4; the 5th sample is not accepted; on the tick, fifo_level=3 and sample_ready=1.
REQ-037 Underrun test: enable=1 with no pushes. underrun pulses once at cycle 160 and again at 320; pwm_out stays 0 throughout.
REQ-038 Boundaries: sample 0xFFFF gives 15 high cycles and 1 low per period; 0x0FFF gives duty 0 and constant low; the duty change occurs only at counter wrap.
REQ-039 Simultaneous events: a push and a tick on the same edge at fifo_level=2 leave fifo_level=2; a push onto an empty FIFO on a tick gives underrun=1 and then fifo_level=1.
REQ-040 Mid-operation: with fifo_level=3, assert reset (or drop enable) mid-period. pwm_out=0 and fifo_level=0 immediately for reset, or on the next edge for enable; after re-enable the first tick arrives at 160 cycles.
